rf_alu_sequencer: RTL and testbench
===================================

// Module: rf_alu_sequencer
// PURPOSE
//  Multi-cycle ALU controller that sits around the 8-entry register file.
//  Accepts one op at a time: Rd <- Rs0 op Rs1. It drives the register-file
//  read selects and consumes the Out_0/Out_1 operands. It then computes ADD,
//  SUB, AND or an iterative shift-add MUL, and writes the result back.
//  Outputs connect directly to Data, Destination_Select, Write_Enable and
//  Source_Select_0/1.
// PARAMETERS
//  W   4   data width; must match the register file W (W >= 2)
// PORTS
//  CLK              in   1   clock; all state updates on rising edge
//  Reset_n          in   1   asynchronous, active-low reset
//  Start            in   1   request; sampled only in IDLE
//  Opcode           in   2   00 ADD, 01 SUB, 10 AND, 11 MUL
//  Src_0            in   3   first source register index
//  Src_1            in   3   second source register index
//  Dst              in   3   destination register index
//  Operand_0        in   W   from register file Out_0
//  Operand_1        in   W   from register file Out_1
//  Source_Select_0  out  3   to register file; registered copy of Src_0
//  Source_Select_1  out  3   to register file; registered copy of Src_1
//  Destination_Select out 3  to register file; registered copy of Dst
//  Data             out  W   write-back value
//  Write_Enable     out  1   high only in WB
//  Busy             out  1   high whenever state != IDLE
//  Done             out  1   one-cycle pulse, coincident with Write_Enable
//  Flag             out  1   carry/borrow/overflow of the last completed op
// BEHAVIOUR
//  - Reset (Reset_n=0, async):
//    - state=IDLE; every output, latched field, operand register and
//      counter = 0.
//  - FSM states:
//    - IDLE: on Start=1, latch Opcode/Src_0/Src_1/Dst, then go to READ.
//      On Start=0, stay in IDLE.
//    - READ: selects are stable; capture Operand_0->A and Operand_1->B;
//      go to EXEC.
//    - EXEC, ADD/SUB/AND: 1 cycle.
//      - Compute the W+1-bit result R; go to WB.
//    - EXEC, MUL: exactly W cycles.
//      - Accumulator is 2W bits, initialised to 0.
//      - Each cycle: if B[0], acc += A<<k; then B >>= 1, k++.
//      - Go to WB when k == W-1 completes.
//    - WB: Write_Enable=1, Done=1, Data=R[W-1:0]; Flag updated; go to IDLE.
//  - Arithmetic and Flag:
//    - ADD: Flag = carry out.
//    - SUB: Data = A - B mod 2^W; Flag = borrow (A<B).
//    - AND: Flag = 0.
//    - MUL: Data = low W bits; Flag = (high W bits != 0).
//  - Latency, counted from the edge where Start is accepted to the
//    WB/Done cycle:
//    - ADD/SUB/AND: 3 cycles.
//    - MUL: 2+W cycles.
//  - Start while Busy (including the WB cycle) is ignored, not queued.
//    The earliest next accept is the cycle after Done.
//  - Hazard-free by construction:
//    - The WB write lands on the edge ending WB.
//    - The next op reads no earlier than 2 cycles later, so Dst==Src is legal.
//  - Data, Destination_Select and Flag hold their values after WB until the
//    next WB. Write_Enable and Done are 0 outside WB.
//  - Reset asserted mid-operation aborts immediately: no write occurs, all
//    outputs return to reset values.
//  - Opcode/Src/Dst changes after acceptance have no effect on the op in
//    flight.
// STRUCTURE
//  - Shared header rf_seq_defs.vh:
//    - opcode localparams OP_ADD/OP_SUB/OP_AND/OP_MUL;
//    - state encodings S_IDLE/S_READ/S_EXEC/S_WB (2-bit).
//  - One sub-module, mul_shift_add #(W):
//    - ports: start, busy-free done, A, B, 2W product;
//    - owns the accumulator and the $clog2(W)+1-bit counter;
//    - same async active-low reset.
//  - Top level holds the FSM, latched fields, ADD/SUB/AND datapath and
//    output registers.
// TESTING (W=4; bench models the register file)
//  1. R1=5, R2=3, ADD Dst=3 ->
//     - Source_Select_0/1 = 1/2 during READ;
//     - WB 3 cycles after Start: R3=8, Flag=0, Done pulse of width 1.
//  2. R1=9, R2=9, ADD -> Data=2, Flag=1.
//     R1=3, R2=5, SUB -> Data=14, Flag=1.
//     AND 12&10 -> Data=8, Flag=0.
//  3. MUL 3*5 -> Data=15, Flag=0, Done 6 cycles after Start.
//     MUL 7*6 -> Data=10, Flag=1.
//  4. Start held high continuously through a MUL ->
//     - exactly one op executes; the second op is accepted the cycle after
//       Done;
//     - Busy is 1 throughout, with exactly one Write_Enable per op.
//  5. Dst==Src_0: R4=6, ADD R4,R4 -> R4 then read by the next ADD R4,R4;
//     final R4=24 mod 16 = 8, Flag=1.
//  6. Reset_n pulled low in the 3rd EXEC cycle of a MUL ->
//     - all outputs 0 asynchronously; no Write_Enable;
//     - after release, a fresh ADD completes normally.

Source files
------------

// File: rtl/rf_alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_alu_sequencer_pkg
// Brief    : Opcode and FSM state encodings shared by the ALU sequencer files.
// Revision : 1.0
// ============================================================================
package rf_alu_sequencer_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mul_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : mul_shift_add
// Brief    : Iterative W-cycle shift-add multiplier; product is the value the
//            accumulator takes at the end of the current step.
// Revision : 1.0
// ============================================================================
module mul_shift_add #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             done,
    output logic [2*W-1:0]   product
);

    localparam int c_cnt_w = $clog2(W) + 1;

    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [2*W-1:0]     r_acc;
    logic [c_cnt_w-1:0] r_k;
    logic               r_active;
    logic [2*W-1:0]     w_addend;
    logic [2*W-1:0]     w_acc_next;

    always_comb begin
        w_addend = '0;
        if (r_b[0]) begin
            w_addend = {{W{1'b0}}, r_a} << r_k;
        end
        w_acc_next = r_acc + w_addend;
    end

    // Combinational done/product let the caller latch the result on the
    // same edge that completes the last step.
    assign done    = r_active && (r_k == c_cnt_w'(W - 1));
    assign product = w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_k      <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_acc    <= '0;
            r_k      <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_acc <= w_acc_next;
            r_b   <= r_b >> 1;
            if (done) begin
                r_active <= 1'b0;
                r_k      <= '0;
            end else begin
                r_k <= r_k + c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rf_alu_sequencer
// Brief    : Multi-cycle Rd <- Rs0 op Rs1 controller around an 8-entry
//            register file (ADD/SUB/AND single-cycle, MUL shift-add).
// Revision : 1.0
// ============================================================================
module rf_alu_sequencer
    import rf_alu_sequencer_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [1:0]   Opcode,
    input  logic [2:0]   Src_0,
    input  logic [2:0]   Src_1,
    input  logic [2:0]   Dst,
    input  logic [W-1:0] Operand_0,
    input  logic [W-1:0] Operand_1,
    output logic [2:0]   Source_Select_0,
    output logic [2:0]   Source_Select_1,
    output logic [2:0]   Destination_Select,
    output logic [W-1:0] Data,
    output logic         Write_Enable,
    output logic         Busy,
    output logic         Done,
    output logic         Flag
);

    state_t         r_state;
    state_t         w_state_next;
    logic [1:0]     r_op;
    logic [2:0]     r_dst;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           w_accept;
    logic           w_mul_start;
    logic           w_mul_done;
    logic           w_to_wb;
    logic [2*W-1:0] w_product;
    logic [W:0]     w_result;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_mul_start  = 1'b0;
        w_to_wb      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                w_mul_start  = (r_op == OP_MUL);
                w_state_next = S_EXEC;
            end
            S_EXEC: begin
                if ((r_op != OP_MUL) || w_mul_done) begin
                    w_to_wb      = 1'b1;
                    w_state_next = S_WB;
                end
            end
            S_WB: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign Busy = (r_state != S_IDLE);

    // Source selects double as the latched source fields so the register
    // file sees stable addresses throughout READ.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_op            <= OP_ADD;
            r_dst           <= '0;
            Source_Select_0 <= '0;
            Source_Select_1 <= '0;
        end else if (w_accept) begin
            r_op            <= Opcode;
            r_dst           <= Dst;
            Source_Select_0 <= Src_0;
            Source_Select_1 <= Src_1;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_a <= '0;
            r_b <= '0;
        end else if (r_state == S_READ) begin
            r_a <= Operand_0;
            r_b <= Operand_1;
        end
    end

    mul_shift_add #(
        .W (W)
    ) u_mul (
        .clk     (CLK),
        .rst_n   (Reset_n),
        .start   (w_mul_start),
        .a       (Operand_0),
        .b       (Operand_1),
        .done    (w_mul_done),
        .product (w_product)
    );

    // Bit W carries the flag: carry for ADD, borrow for SUB.
    always_comb begin
        w_result = '0;
        case (r_op)
            OP_ADD:  w_result = {1'b0, r_a} + {1'b0, r_b};
            OP_SUB:  w_result = {1'b0, r_a} - {1'b0, r_b};
            OP_AND:  w_result = {1'b0, r_a & r_b};
            default: w_result = {(|w_product[2*W-1:W]), w_product[W-1:0]};
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            Data               <= '0;
            Flag               <= 1'b0;
            Destination_Select <= '0;
            Write_Enable       <= 1'b0;
            Done               <= 1'b0;
        end else begin
            Write_Enable <= w_to_wb;
            Done         <= w_to_wb;
            if (w_to_wb) begin
                Data               <= w_result[W-1:0];
                Flag               <= w_result[W];
                Destination_Select <= r_dst;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_alu_sequencer
// Brief    : Scoreboard bench for rf_alu_sequencer with a register-file model.
// Revision : 1.0
// ============================================================================
module tb_rf_alu_sequencer;

    localparam int W = 4;

    logic         CLK;
    logic         Reset_n;
    logic         Start;
    logic [1:0]   Opcode;
    logic [2:0]   Src_0;
    logic [2:0]   Src_1;
    logic [2:0]   Dst;
    logic [W-1:0] Operand_0;
    logic [W-1:0] Operand_1;
    logic [2:0]   Source_Select_0;
    logic [2:0]   Source_Select_1;
    logic [2:0]   Destination_Select;
    logic [W-1:0] Data;
    logic         Write_Enable;
    logic         Busy;
    logic         Done;
    logic         Flag;

    rf_alu_sequencer #(.W(W)) dut (
        .CLK                (CLK),
        .Reset_n            (Reset_n),
        .Start              (Start),
        .Opcode             (Opcode),
        .Src_0              (Src_0),
        .Src_1              (Src_1),
        .Dst                (Dst),
        .Operand_0          (Operand_0),
        .Operand_1          (Operand_1),
        .Source_Select_0    (Source_Select_0),
        .Source_Select_1    (Source_Select_1),
        .Destination_Select (Destination_Select),
        .Data               (Data),
        .Write_Enable       (Write_Enable),
        .Busy               (Busy),
        .Done               (Done),
        .Flag               (Flag)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]   dst;
        logic [W-1:0] data;
        logic         flag;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] rf [8];
    logic [W-1:0] exp_rf [8];
    logic         pre_en;
    logic [2:0]   pre_idx;
    logic [W-1:0] pre_val;
    int           checks;
    int           failures;
    int           we_count;

    assign Operand_0 = rf[Source_Select_0];
    assign Operand_1 = rf[Source_Select_1];

    always @(posedge CLK) begin
        if (Write_Enable) rf[Destination_Select] <= Data;
        else if (pre_en)  rf[pre_idx] <= pre_val;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (Write_Enable) begin
            exp_t e;
            we_count++;
            if (sb_q.size() == 0) begin
                chk("unexpected_we", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("wb_data", 32'(Data), 32'(e.data));
                chk("wb_flag", 32'(Flag), 32'(e.flag));
                chk("wb_dst", 32'(Destination_Select), 32'(e.dst));
                chk("wb_done", 32'(Done), 32'd1);
            end
        end
    end

    task automatic push_op(input logic [1:0] op, input logic [2:0] s0, input logic [2:0] s1,
                           input logic [2:0] d);
        int a, b, r;
        exp_t e;
        a = int'(exp_rf[s0]);
        b = int'(exp_rf[s1]);
        case (op)
            2'b00: begin r = a + b; e.flag = (r > 15); end
            2'b01: begin r = a - b + 16; e.flag = (a < b); end
            2'b10: begin r = a & b; e.flag = 1'b0; end
            default: begin r = a * b; e.flag = (r > 15); end
        endcase
        e.data = W'(r % 16);
        e.dst  = d;
        sb_q.push_back(e);
        exp_rf[d] = e.data;
    endtask

    task automatic set_reg(input logic [2:0] idx, input logic [W-1:0] val);
        @(negedge CLK);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        exp_rf[idx] = val;
        @(negedge CLK);
        pre_en = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [2:0] s0, input logic [2:0] s1,
                         input logic [2:0] d, input int exp_lat);
        int n;
        @(negedge CLK);
        Opcode = op; Src_0 = s0; Src_1 = s1; Dst = d; Start = 1'b1;
        push_op(op, s0, s1, d);
        @(negedge CLK);
        n = 1;
        Start = 1'b0;
        Opcode = ~op; Src_0 = ~s0; Src_1 = ~s1; Dst = ~d;
        chk("read_sel0", 32'(Source_Select_0), 32'(s0));
        chk("read_sel1", 32'(Source_Select_1), 32'(s1));
        while (!Write_Enable && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (!Write_Enable) chk("wb_timeout", 32'd0, 32'd1);
        else chk("latency", 32'(n), 32'(exp_lat));
    endtask

    initial begin
        int n;
        int we0;
        checks = 0; failures = 0; we_count = 0;
        for (int i = 0; i < 8; i++) begin
            rf[i] = '0;
            exp_rf[i] = '0;
        end
        pre_en = 1'b0; pre_idx = '0; pre_val = '0;
        Reset_n = 1'b0; Start = 1'b0; Opcode = '0; Src_0 = '0; Src_1 = '0; Dst = '0;
        repeat (2) @(negedge CLK);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_we", 32'(Write_Enable), 32'd0);
        chk("rst_data", 32'(Data), 32'd0);
        Reset_n = 1'b1;

        // Basic ADD, pulse width and output hold
        set_reg(3'd1, 4'd5);
        set_reg(3'd2, 4'd3);
        do_op(2'b00, 3'd1, 3'd2, 3'd3, 3);
        @(negedge CLK);
        chk("done_width", 32'(Done), 32'd0);
        chk("we_low", 32'(Write_Enable), 32'd0);
        chk("data_hold", 32'(Data), 32'd8);
        chk("dst_hold", 32'(Destination_Select), 32'd3);
        chk("r3_written", 32'(rf[3]), 32'd8);

        // Carry, borrow, AND
        set_reg(3'd1, 4'd9);
        set_reg(3'd2, 4'd9);
        do_op(2'b00, 3'd1, 3'd2, 3'd3, 3);
        set_reg(3'd1, 4'd3);
        set_reg(3'd2, 4'd5);
        do_op(2'b01, 3'd1, 3'd2, 3'd3, 3);
        set_reg(3'd1, 4'd12);
        set_reg(3'd2, 4'd10);
        do_op(2'b10, 3'd1, 3'd2, 3'd3, 3);

        // MUL
        set_reg(3'd1, 4'd3);
        set_reg(3'd2, 4'd5);
        do_op(2'b11, 3'd1, 3'd2, 3'd4, 2 + W);
        set_reg(3'd1, 4'd7);
        set_reg(3'd2, 4'd6);
        do_op(2'b11, 3'd1, 3'd2, 3'd4, 2 + W);

        // Start held high through a MUL; fields change mid-op
        set_reg(3'd1, 4'd3);
        set_reg(3'd2, 4'd5);
        @(negedge CLK);
        #1;
        Opcode = 2'b11; Src_0 = 3'd1; Src_1 = 3'd2; Dst = 3'd5; Start = 1'b1;
        push_op(2'b11, 3'd1, 3'd2, 3'd5);
        we0 = we_count;
        for (n = 1; n <= 2 + W; n++) begin
            @(negedge CLK);
            #1;
            chk("held_busy", 32'(Busy), 32'd1);
            if (n == 3) begin
                Opcode = 2'b00; Src_0 = 3'd3; Src_1 = 3'd4; Dst = 3'd6;
            end
        end
        chk("held_one_we", 32'(we_count - we0), 32'd1);
        @(negedge CLK);
        #1;
        chk("held_idle_gap", 32'(Busy), 32'd0);
        push_op(2'b00, 3'd3, 3'd4, 3'd6);
        @(negedge CLK);
        #1;
        Start = 1'b0;
        chk("held_second_accept", 32'(Busy), 32'd1);
        n = 0;
        while (!Write_Enable && n < 40) begin
            @(negedge CLK);
            n++;
        end
        #1;
        chk("held_second_lat", 32'(n), 32'd2);
        chk("held_two_we", 32'(we_count - we0), 32'd2);

        // Dst == Src back-to-back
        set_reg(3'd4, 4'd6);
        do_op(2'b00, 3'd4, 3'd4, 3'd4, 3);
        do_op(2'b00, 3'd4, 3'd4, 3'd4, 3);
        @(negedge CLK);
        chk("r4_final", 32'(rf[4]), 32'd8);

        // Reset during the third EXEC cycle of a MUL
        set_reg(3'd1, 4'd7);
        set_reg(3'd2, 4'd6);
        @(negedge CLK);
        Opcode = 2'b11; Src_0 = 3'd1; Src_1 = 3'd2; Dst = 3'd7; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        repeat (3) @(negedge CLK);
        Reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_data", 32'(Data), 32'd0);
        chk("abort_flag", 32'(Flag), 32'd0);
        chk("abort_sel0", 32'(Source_Select_0), 32'd0);
        chk("abort_dst", 32'(Destination_Select), 32'd0);
        chk("abort_we", 32'(Write_Enable), 32'd0);
        repeat (3) @(negedge CLK);
        Reset_n = 1'b1;
        repeat (8) @(negedge CLK);
        chk("abort_no_write", 32'(rf[7]), 32'(exp_rf[7]));
        do_op(2'b00, 3'd1, 3'd2, 3'd7, 3);

        repeat (3) @(negedge CLK);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
